// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master memory arbiter: master IDs, access sizes, grant FSM states.
package mem_arb_pkg;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_e;

  function automatic arb_state_e hold_of(input logic mst);
    return (mst == MST_DATA) ? HOLD_D : HOLD_I;
  endfunction

endpackage

// File: rtl/ot_fifo.sv
// Outstanding-transaction ID FIFO: remembers which master owns each accepted request, in order.
module ot_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (inst/data) arbiter onto one SRAM-like slave with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over inst.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int OT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_e state;
  logic       pick, sel, active, hs, rsp;
  logic       fifo_full, fifo_empty, head_id;

`ifdef MEM_ARB_RR_EN
  logic prio;  // master preferred on the next contended IDLE cycle

  always_comb begin
    pick = data_req ? MST_DATA : MST_INST;
    if (inst_req && data_req) pick = prio;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   prio <= MST_INST;
    else if (hs) prio <= ~sel;
  end
`else
  always_comb pick = data_req ? MST_DATA : MST_INST;
`endif

  // Once a request has been presented it owns the bus until accepted
  always_comb begin
    sel    = pick;
    active = inst_req || data_req;
    case (state)
      HOLD_I:  begin sel = MST_INST; active = 1'b1; end
      HOLD_D:  begin sel = MST_DATA; active = 1'b1; end
      default: ;
    endcase
  end

  assign mem_req      = active && !fifo_full && !reset;
  assign hs           = mem_req && mem_addr_ok;
  assign inst_addr_ok = hs && (sel == MST_INST);
  assign data_addr_ok = hs && (sel == MST_DATA);

  assign mem_wr    = (sel == MST_DATA) ? data_wr    : 1'b0;
  assign mem_size  = (sel == MST_DATA) ? data_size  : SIZE_WORD;
  assign mem_wstrb = (sel == MST_DATA) ? data_wstrb : 4'h0;
  assign mem_addr  = (sel == MST_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (sel == MST_DATA) ? data_wdata : 32'h0;

  assign rsp          = mem_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = rsp && (head_id == MST_INST);
  assign data_data_ok = rsp && (head_id == MST_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (active && !hs) state <= hold_of(sel);
        HOLD_I,
        HOLD_D:  if (hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ot_fifo #(.DEPTH(OT_DEPTH)) u_ot_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (hs),
    .pop   (rsp),
    .din   (sel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_id)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a queue-based reference model.
module tb_mem_arbiter;

  localparam int OT_DEPTH = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int NONE = -1;
  localparam int INST = 0;
  localparam int DATA = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd2;
  logic [3:0]  data_wstrb = 4'h0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.OT_DEPTH(OT_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of outstanding owners, the master locked onto the bus, RR preference
  int q[$];
  int owner = NONE;
  int prio = INST;
  int last_cand = NONE;
  bit last_hs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic model_step();
    bit full, exp_req, hs, rsp;
    int cand, rid;
    full = (q.size() >= OT_DEPTH);
    if (owner != NONE)            cand = owner;
    else if (inst_req && data_req) cand = RR ? prio : DATA;
    else if (data_req)            cand = DATA;
    else if (inst_req)            cand = INST;
    else                          cand = NONE;
    exp_req = !reset && (cand != NONE) && !full;
    hs = exp_req && mem_addr_ok;
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(hs && cand == INST));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(hs && cand == DATA));
    if (exp_req) begin
      chk("mem_addr",  mem_addr,        (cand == DATA) ? data_addr : inst_addr);
      chk("mem_wr",    32'(mem_wr),     (cand == DATA) ? 32'(data_wr) : 32'd0);
      chk("mem_size",  32'(mem_size),   (cand == DATA) ? 32'(data_size) : 32'd2);
      chk("mem_wstrb", 32'(mem_wstrb),  (cand == DATA) ? 32'(data_wstrb) : 32'd0);
      chk("mem_wdata", mem_wdata,       (cand == DATA) ? data_wdata : 32'd0);
    end
    rsp = !reset && mem_data_ok && (q.size() > 0);
    rid = rsp ? q[0] : NONE;
    chk("inst_data_ok", 32'(inst_data_ok), 32'(rid == INST));
    chk("data_data_ok", 32'(data_data_ok), 32'(rid == DATA));
    if (rid == INST) chk("inst_rdata", inst_rdata, mem_rdata);
    if (rid == DATA) chk("data_rdata", data_rdata, mem_rdata);
    @(posedge clk);
    if (reset) begin
      q.delete();
      owner = NONE;
      prio  = INST;
      hs    = 1'b0;
    end else begin
      if (rsp) void'(q.pop_front());
      if (hs)  q.push_back(cand);
      owner = (cand != NONE && !hs) ? cand : NONE;
      if (hs) prio = 1 - cand;
    end
    last_hs   = hs;
    last_cand = cand;
    #1;
  endtask

  task automatic cyc();
    at_neg();
    model_step();
  endtask

  initial begin
    // Reset with everything asserted: outputs must stay quiet
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    at_neg();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    model_step();
    cyc();
    reset = 1'b0;

`ifdef MEM_ARB_RR_EN
    // Continuous contention alternates grants starting from inst
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("rr_inst_grant", 32'(inst_addr_ok), 32'(k % 2 == 0));
      chk("rr_data_grant", 32'(data_addr_ok), 32'(k % 2 == 1));
      model_step();
    end
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    cyc(); cyc();
`endif
    mem_data_ok = 1'b0; inst_req = 1'b0; data_req = 1'b0;

    // Single fetch: combinational accept, then response routed to inst
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1;
    at_neg();
    chk("r030_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("r030_inst_aok", 32'(inst_addr_ok), 32'd1);
    model_step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C01_0000;
    at_neg();
    chk("r030_inst_dok", 32'(inst_data_ok), 32'd1);
    chk("r030_inst_rdata", inst_rdata, 32'h3C01_0000);
    model_step();
    mem_data_ok = 1'b0;

`ifndef MEM_ARB_RR_EN
    // Contention under fixed priority: data is held through slave back-pressure
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
    mem_addr_ok = 1'b0;
    repeat (3) begin
      at_neg();
      chk("r031_hold_addr", mem_addr, 32'h0000_2000);
      model_step();
    end
    mem_addr_ok = 1'b1;
    at_neg();
    chk("r031_data_aok", 32'(data_addr_ok), 32'd1);
    chk("r031_inst_aok", 32'(inst_addr_ok), 32'd0);
    model_step();
    data_req = 1'b0;
    at_neg();
    chk("r031_inst_next", 32'(inst_addr_ok), 32'd1);
    chk("r031_inst_addr", mem_addr, 32'h0000_1000);
    model_step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
    at_neg();
    chk("r031_rsp_data", 32'(data_data_ok), 32'd1);
    model_step();
    mem_rdata = 32'h6666_6666;
    at_neg();
    chk("r031_rsp_inst", 32'(inst_data_ok), 32'd1);
    model_step();
    mem_data_ok = 1'b0;
`endif

    // Full FIFO blocks even with a pop in the same cycle
    inst_req = 1'b1; inst_addr = 32'h0000_0100; mem_addr_ok = 1'b1;
    cyc();
    inst_addr = 32'h0000_0104;
    cyc();
    inst_addr = 32'h0000_0108; mem_data_ok = 1'b1; mem_rdata = 32'h0000_000A;
    at_neg();
    chk("r032_full_req", 32'(mem_req), 32'd0);
    chk("r032_full_aok", 32'(inst_addr_ok), 32'd0);
    chk("r032_pop_dok", 32'(inst_data_ok), 32'd1);
    model_step();
    mem_data_ok = 1'b0;
    at_neg();
    chk("r032_retry_req", 32'(mem_req), 32'd1);
    chk("r032_retry_aok", 32'(inst_addr_ok), 32'd1);
    model_step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_000B;
    cyc(); cyc();
    mem_data_ok = 1'b0;

    // In-order routing of an inst then a data response
    inst_req = 1'b1; inst_addr = 32'h0000_0200; mem_addr_ok = 1'b1;
    cyc();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0300;
    cyc();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    at_neg();
    chk("r033_first_inst", 32'(inst_data_ok), 32'd1);
    chk("r033_first_rdata", inst_rdata, 32'h1111_1111);
    chk("r033_first_nodata", 32'(data_data_ok), 32'd0);
    model_step();
    mem_rdata = 32'h2222_2222;
    at_neg();
    chk("r033_second_data", 32'(data_data_ok), 32'd1);
    chk("r033_second_rdata", data_rdata, 32'h2222_2222);
    chk("r033_second_noinst", 32'(inst_data_ok), 32'd0);
    model_step();
    mem_data_ok = 1'b0;

    // Reset with two outstanding, then a stray response
    inst_req = 1'b1; inst_addr = 32'h0000_0400; mem_addr_ok = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    at_neg();
    chk("r035_rst_req", 32'(mem_req), 32'd0);
    chk("r035_rst_aok", 32'(inst_addr_ok), 32'd0);
    model_step();
    cyc();
    reset = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    at_neg();
    chk("r035_stray", 32'({inst_data_ok, data_data_ok}), 32'd0);
    model_step();
    mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0500; mem_addr_ok = 1'b1;
    at_neg();
    chk("r035_fresh_aok", 32'(data_addr_ok), 32'd1);
    model_step();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0077;
    at_neg();
    chk("r035_fresh_dok", 32'(data_data_ok), 32'd1);
    model_step();
    mem_data_ok = 1'b0;

    // Randomized traffic; masters hold their payload until accepted
    for (int c = 0; c < 600; c++) begin
      mem_addr_ok = ($urandom % 4) != 0;
      mem_data_ok = $urandom % 2;
      mem_rdata   = $urandom;
      cyc();
      if (!inst_req || (last_hs && last_cand == INST)) begin
        inst_req  = $urandom % 2;
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req || (last_hs && last_cand == DATA)) begin
        data_req   = $urandom % 2;
        data_wr    = $urandom % 2;
        data_size  = 2'($urandom % 3);
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter OT_DEPTH, default 2: maximum accepted-but-unanswered transactions, power of two, range 2..8.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Ports inst_req/inst_addr, input, 1/32: instruction-fetch read request and word address.
REQ-005 Ports inst_addr_ok/inst_data_ok/inst_rdata, output, 1/1/32: fetch request accepted; read data valid; read data.
REQ-006 Ports data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata, input, 1/1/2/4/32/32: data-side request; write flag; size (0=byte, 1=half, 2=word); byte strobes; address; write data.
REQ-007 Ports data_addr_ok/data_data_ok/data_rdata, output, 1/1/32: data request accepted; response (read data or write ack); read data.
REQ-008 Ports mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata, output, 1/1/2/4/32/32: request to the single shared SRAM-like slave.
REQ-009 Ports mem_addr_ok/mem_data_ok/mem_rdata, input, 1/1/32: slave accept, slave response, slave read data.

Function
REQ-010 A handshake completes on a cycle with mem_req && mem_addr_ok; the granted master's *_addr_ok mirrors mem_addr_ok combinationally; the other master's *_addr_ok is 0.
REQ-011 Inst requests drive mem_wr=0, mem_size=2, mem_wstrb=4'h0, mem_wdata=0.
REQ-012 Grant FSM states: IDLE, HOLD_I, HOLD_D.
REQ-013 IDLE: pick a master per REQ-025; if mem_addr_ok=0 that cycle, go to HOLD_I/HOLD_D; otherwise stay in IDLE.
REQ-014 HOLD_x: keep the same master and payload until the handshake completes, then return to IDLE; a competing request never preempts.
REQ-015 On each handshake, push the master ID into the outstanding FIFO (depth OT_DEPTH).
REQ-016 On each mem_data_ok, pop the head ID; route mem_data_ok to that master's *_data_ok and mem_rdata to its *_rdata; the other *_data_ok stays 0.
REQ-017 Responses return in acceptance order; there is no reordering.
REQ-018 FIFO full: mem_req=0 and both *_addr_ok=0, even if a pop occurs that cycle.
REQ-019 FIFO full in HOLD_x: remain in HOLD_x until not full.
REQ-020 Push and pop in the same cycle leave the count unchanged.
REQ-021 mem_data_ok while the FIFO is empty is ignored; there is no underflow, and both *_data_ok stay 0.
REQ-022 Latency: request-to-mem_req is 0 cycles (combinational); response routing is 0 cycles.

Reset
REQ-023 While reset is asserted: FSM=IDLE, FIFO empty, grant pointer = inst, and all outputs (mem_req, both *_addr_ok, both *_data_ok) are 0.
REQ-024 Reset mid-operation discards outstanding IDs; responses that arrive after reset deassertion fall under REQ-021.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: round-robin arbitration in IDLE; the master granted last has lowest priority next; the pointer updates only on a completed handshake.
REQ-026 Macro MEM_ARB_RR_EN undefined: fixed priority, data over inst; the pointer logic is absent.

Structure
REQ-027 Package mem_arb_pkg holds the master-ID encoding (MST_INST=0, MST_DATA=1), size encodings, and the FSM state encoding.
REQ-028 The outstanding FIFO is sub-module ot_fifo (parameterised by depth, 1-bit payload, push/pop/full/empty/head).
REQ-029 The arbiter is 120-400 lines of RTL, excluding the package.

Verification
REQ-030 Only inst_req=1, addr 0xBFC00000, mem_addr_ok=1 -> mem_addr=0xBFC00000, inst_addr_ok=1 the same cycle; mem_data_ok with rdata 0x3C010000 -> inst_data_ok=1, inst_rdata=0x3C010000.
REQ-031 Both requesting, fixed priority, mem_addr_ok=0 for 3 cycles -> HOLD_D; mem_addr stays at the data address for all cycles; inst never granted until the data handshake completes.
REQ-032 OT_DEPTH=2, two accepted reads with no mem_data_ok -> third request sees mem_req=0; a pop in that cycle still blocks; the request is accepted the next cycle.
REQ-033 Accept inst then data, then two mem_data_ok with 0x11111111 then 0x22222222 -> inst_rdata=0x11111111, then data_rdata=0x22222222; no cross-routing.
REQ-034 MEM_ARB_RR_EN defined, both requesting continuously, mem_addr_ok=1 -> grants alternate inst, data, inst, data.
REQ-035 Reset asserted with 2 outstanding, then a stray mem_data_ok after release -> both *_data_ok stay 0 and the FIFO count stays 0.
